// File: rtl/wsg_sound.sv
// Namco-style 3-voice waveform sound generator: CPU register file, per-voice phase
// accumulators, wave PROM fetch, volume scaling and a 3-voice mix per output sample.
module wsg_sound #(
  parameter int CLK_HZ  = 47828000,
  parameter int STEP_HZ = 72000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       sound_en,
  output logic       prom_rd,
  output logic [7:0] prom_addr,
  input  logic [3:0] prom_data_a,
  input  logic [3:0] prom_data_b,
  output logic [9:0] sample,
  output logic       sample_valid
);

  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] CNT_TERM  = CW'(DIV);
  localparam logic [CW-1:0] CNT_FETCH = CW'(DIV / 2 - 1);

  logic [3:0]        regs [32];
  logic [19:0]       acc  [3];
  logic [CW-1:0]     cnt;
  logic [1:0]        ch;
  logic [9:0]        sum;
  logic [7:0]        contrib;
  logic              rd_q;

  logic [4:0]        base;
  logic [3:0]        wave;
  logic [3:0]        vol;
  logic [19:0]       freq;
  logic [3:0]        d;
  logic signed [9:0] c_calc;
  logic [9:0]        contrib_ext;

  // Voice register map: each voice's block sits 5 registers above the previous one,
  // and only voice 0 owns a frequency low nibble (reg 0x10).
  always_comb begin
    base = 5'd0;
    case (ch)
      2'd1:    base = 5'd5;
      2'd2:    base = 5'd10;
      default: base = 5'd0;
    endcase
    wave = regs[5'd5 + base];
    vol  = regs[5'd21 + base];
    freq = {regs[5'd20 + base], regs[5'd19 + base], regs[5'd18 + base],
            regs[5'd17 + base], (ch == 2'd0) ? regs[16] : 4'h0};
    d    = wave[3] ? prom_data_b : prom_data_a;
    c_calc = '0;
    if (sound_en)
      c_calc = $signed({6'b0, vol}) * ($signed({6'b0, d}) - 10'sd7);
    contrib_ext = {{2{contrib[7]}}, contrib};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      for (int i = 0; i < 3; i++) acc[i] <= '0;
      cnt          <= '0;
      ch           <= '0;
      sum          <= '0;
      contrib      <= '0;
      rd_q         <= 1'b0;
      prom_rd      <= 1'b0;
      prom_addr    <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      prom_rd      <= 1'b0;
      sample_valid <= 1'b0;

      if (wr_en)
        regs[wr_addr] <= wr_data;

      cnt <= (cnt == CNT_TERM) ? '0 : cnt + 1'b1;

      // Issue the fetch one cycle early so prom_rd is high while cnt sits at DIV/2.
      if (cnt == CNT_FETCH) begin
        prom_rd   <= 1'b1;
        prom_addr <= {wave[2:0], acc[ch][17:13]};
      end

      rd_q <= prom_rd;
      if (rd_q)
        contrib <= c_calc[7:0];

      if (cnt == CNT_TERM) begin
        acc[ch] <= acc[ch] + freq;
        if (ch == 2'd2) begin
          sample       <= sum + contrib_ext;
          sum          <= '0;
          ch           <= '0;
          sample_valid <= 1'b1;
        end else begin
          sum <= sum + contrib_ext;
          ch  <= ch + 2'd1;
        end
      end
    end
  end

endmodule
